axi_demo_wr_consumer: RTL

AXI4 write-channel consumer for the axiDemo system; it is the `ADDR_ID_TOP_UCONSUMER` endpoint that terminates writes from the demo producer. It accepts one AW burst at a time, absorbs its W beats into a small byte-strobed local word memory, and returns one B response per burst. A combinational side read port exposes the memory to the testbench and the demo readback logic.

---
 rtl/axi_demo_wr_consumer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/axi_demo_wr_consumer.sv
// rtl/axi_demo_wr_consumer.sv - AXI4 write-channel consumer with byte-strobed local word memory
// Optional AXI_DEMO_WR_ERR_CHECK_EN: wlast/range checking with SLVERR response.
module axi_demo_wr_consumer #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_STROBE_WIDTH  = 4,
  parameter int ID_WIDTH          = 4,
  parameter int MEM_DEPTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] awaddr,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [7:0]                   awlen,
  input  logic [1:0]                   awburst,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic [AXI_DATA_WIDTH-1:0]    wdata,
  input  logic [AXI_STROBE_WIDTH-1:0]  wstrb,
  input  logic                         wlast,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_idx,
  output logic [AXI_DATA_WIDTH-1:0]    rd_data
);

  localparam int LANE_W = $clog2(AXI_STROBE_WIDTH);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic                           live_q;
  logic [AXI_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [ID_WIDTH-1:0]            id_q, id_d;
  logic [7:0]                     len_q, len_d;
  logic [1:0]                     burst_q, burst_d;
  logic [7:0]                     cnt_q, cnt_d;
  logic                           err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0]      mem_q [MEM_DEPTH];

  logic                           beat_fire;
  logic                           last_beat;
  logic                           in_range;
  logic                           beat_err;
  logic                           write_en;
  logic [IDX_W-1:0]               word_idx;

  // live_q keeps awready low while reset is held, since it must not follow rst combinationally
  assign awready = (state_q == S_IDLE) && live_q;
  assign wready  = (state_q == S_DATA);
  assign bvalid  = (state_q == S_RESP);
  assign bid     = id_q;
  assign bresp   = err_q ? 2'b10 : 2'b00;
  assign rd_data = mem_q[rd_idx];

  assign word_idx  = addr_q[LANE_W +: IDX_W];
  assign beat_fire = wvalid && wready;
  assign last_beat = (cnt_q == len_q);

`ifdef AXI_DEMO_WR_ERR_CHECK_EN
  localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * longint'(AXI_STROBE_WIDTH);
  assign in_range = (64'(addr_q) < MEM_BYTES);
  assign beat_err = (wlast != last_beat) || !in_range;
`else
  logic unused_wlast;
  assign unused_wlast = wlast;
  assign in_range     = 1'b1;
  assign beat_err     = 1'b0;
`endif

  assign write_en = beat_fire && in_range;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (awvalid && awready) begin
          addr_d  = awaddr;
          id_d    = awid;
          len_d   = awlen;
          burst_d = awburst;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (beat_fire) begin
          cnt_d = cnt_q + 8'd1;
          err_d = err_q || beat_err;
          // WRAP is deliberately treated as INCR; only FIXED holds the address
          if (burst_q != 2'b00) begin
            addr_d = addr_q + AXI_ADDRESS_WIDTH'(AXI_STROBE_WIDTH);
          end
          if (last_beat) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (write_en) begin
      for (int b = 0; b < AXI_STROBE_WIDTH; b++) begin
        if (wstrb[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
